// File: rtl/clkdiv_wb_pkg.sv
// clkdiv_wb_pkg: register map, CTRL bit positions and reset values shared by
// the Wishbone register block and its clock divider core.
package clkdiv_wb_pkg;

    // Byte offsets of the registers within the decoded window
    localparam logic [7:0] OFF_ID      = 8'h00;
    localparam logic [7:0] OFF_CTRL    = 8'h04;
    localparam logic [7:0] OFF_DIV     = 8'h08;
    localparam logic [7:0] OFF_COUNT   = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH = 8'h10;

    // CTRL bit indices
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // Divider terminal count after reset
    localparam logic [15:0] DIV_RESET = 16'd1;

    // Register selected by the current bus address
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ID,
        SEL_CTRL,
        SEL_DIV,
        SEL_COUNT,
        SEL_SCRATCH
    } reg_sel_e;

    // Replace only the bytes whose lane enable is set
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) result[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: programmable divider. The internal counter runs 0..div_n and
// clk_div toggles each time it wraps, giving a period of 2*(div_n+1) clocks.
// count tallies rising edges of clk_div.
module clkdiv_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] div_n,
    output logic        clk_div,
    output logic [31:0] count
);

    logic [15:0] cnt;

    // Divider counter, divided clock and edge tally; clear beats a toggle,
    // and ">=" lets a shrunken div_n wrap on the very next enabled cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            count   <= '0;
        end else if (clr) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            count   <= '0;
        end else if (en) begin
            if (cnt >= div_n) begin
                cnt     <= '0;
                clk_div <= ~clk_div;
                if (!clk_div) count <= count + 32'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_wb_regs.sv
// clkdiv_wb_regs: Wishbone slave exposing ID, CTRL, DIV, COUNT and SCRATCH
// registers around a clkdiv_core. Every request gets a single-cycle ack one
// cycle later, with registered read data valid only during the ack.
module clkdiv_wb_regs
    import clkdiv_wb_pkg::*;
#(
    parameter int          ADR_W    = 7,
    parameter logic [31:0] ID_VALUE = 32'h00ABCD01
) (
    input  logic        WB_CLK,
    input  logic        WB_RST_N,
    input  logic [16:0] WBs_ADR,
    input  logic        WBs_CYC,
    input  logic        WBs_STB,
    input  logic        WBs_WE,
    input  logic        WBs_RD,
    input  logic [3:0]  WBs_BYTE_STB,
    input  logic [31:0] WBs_WR_DAT,
    output logic [31:0] WBs_RD_DAT,
    output logic        WBs_ACK,
    output logic        clk_div_out
);

    logic             req;
    logic             wr_req;
    logic             rd_req;
    logic [ADR_W-1:0] adr;
    reg_sel_e         sel;
    logic             ctrl_en;
    logic [15:0]      div_n;
    logic [31:0]      scratch;
    logic             clr;
    logic [31:0]      count;
    logic [31:0]      rd_val;
    logic             unused_ok;

    // A pending ack masks the request, so back-to-back strobes alternate
    assign req    = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign wr_req = req & WBs_WE;
    assign rd_req = req & ~WBs_WE;
    assign adr    = {WBs_ADR[ADR_W-1:2], 2'b00};

    // WBs_RD is redundant with ~WBs_WE; upper and byte address bits are not decoded
    assign unused_ok = &{1'b0, WBs_RD, WBs_ADR[16:ADR_W], WBs_ADR[1:0]};

    // CLR is a strobe derived from the write itself and is never stored
    assign clr = wr_req & (sel == SEL_CTRL) & WBs_BYTE_STB[0] & WBs_WR_DAT[CTRL_CLR_BIT];

    // Address decode into a register select
    // NOTE: assigning a default before any branch keeps combinational blocks
    // free of inferred latches.
    always_comb begin
        sel = SEL_NONE;
        if      (adr == ADR_W'(OFF_ID))      sel = SEL_ID;
        else if (adr == ADR_W'(OFF_CTRL))    sel = SEL_CTRL;
        else if (adr == ADR_W'(OFF_DIV))     sel = SEL_DIV;
        else if (adr == ADR_W'(OFF_COUNT))   sel = SEL_COUNT;
        else if (adr == ADR_W'(OFF_SCRATCH)) sel = SEL_SCRATCH;
    end

    // Read mux; unused bits and unmapped addresses read as zero
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_ID:      rd_val = ID_VALUE;
            SEL_CTRL:    rd_val[CTRL_EN_BIT] = ctrl_en;
            SEL_DIV:     rd_val[15:0] = div_n;
            SEL_COUNT:   rd_val = count;
            SEL_SCRATCH: rd_val = scratch;
            default:     rd_val = '0;
        endcase
    end

    // Ack and read data, both registered at the request edge
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            WBs_ACK    <= 1'b0;
            WBs_RD_DAT <= '0;
        end else begin
            WBs_ACK    <= req;
            WBs_RD_DAT <= rd_req ? rd_val : '0;
        end
    end

    // Writable registers, committed on the edge that raises the ack
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            ctrl_en <= 1'b0;
            div_n   <= DIV_RESET;
            scratch <= '0;
        end else if (wr_req) begin
            case (sel)
                SEL_CTRL:    if (WBs_BYTE_STB[0]) ctrl_en <= WBs_WR_DAT[CTRL_EN_BIT];
                SEL_DIV:     div_n   <= 16'(merge_lanes({16'h0000, div_n}, WBs_WR_DAT, WBs_BYTE_STB));
                SEL_SCRATCH: scratch <= merge_lanes(scratch, WBs_WR_DAT, WBs_BYTE_STB);
                default:     ;
            endcase
        end
    end

    clkdiv_core u_core (
        .clk     (WB_CLK),
        .rst_n   (WB_RST_N),
        .en      (ctrl_en),
        .clr     (clr),
        .div_n   (div_n),
        .clk_div (clk_div_out),
        .count   (count)
    );

endmodule

// File: tb/tb_clkdiv_wb_regs.sv
// tb_clkdiv_wb_regs: directed bench for clkdiv_wb_regs with a cycle-level
// behavioural model checked against the DUT on every falling edge.
module tb_clkdiv_wb_regs;

    localparam logic [31:0] ID = 32'h00ABCD01;

    logic        WB_CLK = 1'b0;
    logic        WB_RST_N;
    logic [16:0] WBs_ADR = '0;
    logic        WBs_CYC = 1'b0;
    logic        WBs_STB = 1'b0;
    logic        WBs_WE = 1'b0;
    logic        WBs_RD = 1'b0;
    logic [3:0]  WBs_BYTE_STB = '0;
    logic [31:0] WBs_WR_DAT = '0;
    logic [31:0] WBs_RD_DAT;
    logic        WBs_ACK;
    logic        clk_div_out;

    int tests_run = 0;
    int tests_failed = 0;

    clkdiv_wb_regs dut (
        .WB_CLK       (WB_CLK),
        .WB_RST_N     (WB_RST_N),
        .WBs_ADR      (WBs_ADR),
        .WBs_CYC      (WBs_CYC),
        .WBs_STB      (WBs_STB),
        .WBs_WE       (WBs_WE),
        .WBs_RD       (WBs_RD),
        .WBs_BYTE_STB (WBs_BYTE_STB),
        .WBs_WR_DAT   (WBs_WR_DAT),
        .WBs_RD_DAT   (WBs_RD_DAT),
        .WBs_ACK      (WBs_ACK),
        .clk_div_out  (clk_div_out)
    );

    always #5 WB_CLK = ~WB_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_ack = 1'b0;
    logic [31:0] m_rd = '0;
    logic        m_clk = 1'b0;
    logic        m_en = 1'b0;
    logic [15:0] m_div = 16'd1;
    logic [31:0] m_count = '0;
    logic [31:0] m_scr = '0;
    int          m_phase = 0;

    always @(posedge WB_CLK or negedge WB_RST_N) begin
        logic        mreq;
        logic        mclr;
        logic [7:0]  off;
        logic [31:0] rv;
        if (!WB_RST_N) begin
            m_ack = 1'b0; m_rd = '0; m_clk = 1'b0; m_en = 1'b0;
            m_div = 16'd1; m_count = '0; m_scr = '0; m_phase = 0;
        end else begin
            mreq = WBs_CYC && WBs_STB && !m_ack;
            off  = {1'b0, WBs_ADR[6:2], 2'b00};
            rv   = '0;
            if (mreq && !WBs_WE) begin
                case (off)
                    8'h00: rv = ID;
                    8'h04: rv = {31'b0, m_en};
                    8'h08: rv = {16'b0, m_div};
                    8'h0C: rv = m_count;
                    8'h10: rv = m_scr;
                    default: rv = '0;
                endcase
            end
            mclr = mreq && WBs_WE && off == 8'h04 && WBs_BYTE_STB[0] && WBs_WR_DAT[1];
            if (mclr) begin
                m_phase = 0; m_clk = 1'b0; m_count = '0;
            end else if (m_en) begin
                if (m_phase >= int'(m_div)) begin
                    m_phase = 0;
                    m_clk = !m_clk;
                    if (m_clk) m_count = m_count + 1;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            if (mreq && WBs_WE) begin
                case (off)
                    8'h04: if (WBs_BYTE_STB[0]) m_en = WBs_WR_DAT[0];
                    8'h08: for (int b = 0; b < 2; b++) if (WBs_BYTE_STB[b]) m_div[b*8 +: 8] = WBs_WR_DAT[b*8 +: 8];
                    8'h10: for (int b = 0; b < 4; b++) if (WBs_BYTE_STB[b]) m_scr[b*8 +: 8] = WBs_WR_DAT[b*8 +: 8];
                    default: ;
                endcase
            end
            m_ack = mreq;
            m_rd  = rv;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge WB_CLK) begin
        check("cyc_ack", {31'b0, WBs_ACK}, {31'b0, m_ack});
        check("cyc_rd_dat", WBs_RD_DAT, m_rd);
        check("cyc_clk_div", {31'b0, clk_div_out}, {31'b0, m_clk});
    end

    // ---------------- bus tasks ----------------
    task automatic wb_xfer(input logic [16:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdat);
        int lat;
        @(negedge WB_CLK);
        WBs_ADR = a; WBs_WE = we; WBs_RD = !we; WBs_WR_DAT = d; WBs_BYTE_STB = s;
        WBs_CYC = 1'b1; WBs_STB = 1'b1;
        lat = 0;
        rdat = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge WB_CLK);
            if (WBs_ACK) begin
                lat = i;
                rdat = WBs_RD_DAT;
                break;
            end
        end
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0; WBs_RD = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        wb_xfer(a, 1'b1, d, s, unused_rd);
    endtask

    task automatic rd_check(input string name, input logic [16:0] a, input logic [31:0] exp);
        logic [31:0] got;
        wb_xfer(a, 1'b0, '0, 4'hF, got);
        check(name, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rdat;
        int rise_at[3];
        int tog_at[3];
        int nr;
        int nchg;
        int waited;
        logic prev;

        WB_RST_N = 1'b1;
        #1 WB_RST_N = 1'b0;
        repeat (2) @(negedge WB_CLK);
        check("rst_ack", {31'b0, WBs_ACK}, 32'd0);
        check("rst_rd_dat", WBs_RD_DAT, 32'd0);
        check("rst_clk_div", {31'b0, clk_div_out}, 32'd0);
        WB_RST_N = 1'b1;

        // Reset values and ack shape
        rd_check("id_after_reset", 17'h00, ID);
        @(negedge WB_CLK);
        check("ack_one_cycle", {31'b0, WBs_ACK}, 32'd0);
        rd_check("div_after_reset", 17'h08, 32'h00000001);
        rd_check("ctrl_after_reset", 17'h04, 32'h0);
        rd_check("count_after_reset", 17'h0C, 32'h0);
        rd_check("scratch_after_reset", 17'h10, 32'h0);

        // Byte lanes on SCRATCH
        wr(17'h10, 32'hFFFFFFFF, 4'hF);
        wr(17'h10, 32'h12345678, 4'b0101);
        rd_check("scratch_lanes", 17'h10, 32'hFF34FF78);
        rd_check("scratch_alias_hi_adr", 17'h10010, 32'hFF34FF78);

        // Read-only, unmapped and reserved bits
        wr(17'h00, 32'hDEADBEEF, 4'hF);
        rd_check("id_ro", 17'h00, ID);
        wr(17'h0C, 32'h55555555, 4'hF);
        rd_check("count_ro", 17'h0C, 32'h0);
        wr(17'h08, 32'hFFFF0005, 4'hF);
        rd_check("div_upper_zero", 17'h08, 32'h00000005);
        wr(17'h40, 32'hA5A5A5A5, 4'hF);
        rd_check("unmapped_read", 17'h40, 32'h0);

        // Back-to-back requests are acked on alternate cycles
        @(negedge WB_CLK);
        WBs_ADR = 17'h00; WBs_WE = 1'b0; WBs_RD = 1'b1; WBs_CYC = 1'b1; WBs_STB = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge WB_CLK);
            check("b2b_ack_pattern", {31'b0, WBs_ACK}, {31'b0, k[0]});
        end
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_RD = 1'b0;

        // DIV=3 with EN: period 8, about 10 rising edges in 80 cycles
        wr(17'h08, 32'd3, 4'hF);
        wr(17'h04, 32'd1, 4'hF);
        repeat (80) @(negedge WB_CLK);
        wb_xfer(17'h0C, 1'b0, '0, 4'hF, rdat);
        check("count_about_10", {31'b0, (rdat >= 32'd9 && rdat <= 32'd11)}, 32'd1);
        nr = 0;
        rise_at = '{default: -100};
        prev = clk_div_out;
        for (int k = 1; k <= 40 && nr < 3; k++) begin
            @(negedge WB_CLK);
            if (clk_div_out && !prev) begin
                rise_at[nr] = k;
                nr++;
            end
            prev = clk_div_out;
        end
        check("period8_a", 32'(rise_at[1] - rise_at[0]), 32'd8);
        check("period8_b", 32'(rise_at[2] - rise_at[1]), 32'd8);

        // CLR: COUNT and divider restart, CLR reads back 0
        wr(17'h04, 32'd3, 4'hF);
        check("clr_clk_div_low", {31'b0, clk_div_out}, 32'd0);
        rd_check("count_after_clr", 17'h0C, 32'h0);
        rd_check("ctrl_after_clr", 17'h04, 32'h1);

        // EN=0 holds the divided clock
        wr(17'h04, 32'd0, 4'hF);
        prev = clk_div_out;
        nchg = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge WB_CLK);
            if (clk_div_out !== prev) nchg++;
        end
        check("en0_hold", 32'(nchg), 32'd0);

        // N=0 toggles every cycle
        wr(17'h08, 32'd0, 4'hF);
        wr(17'h04, 32'd1, 4'hF);
        prev = clk_div_out;
        for (int k = 0; k < 4; k++) begin
            @(negedge WB_CLK);
            check("n0_toggle", {31'b0, clk_div_out}, {31'b0, ~prev});
            prev = clk_div_out;
        end

        // Shrinking DIV mid-count: toggle next cycle, then every 11
        wr(17'h08, 32'd100, 4'hF);
        wr(17'h04, 32'd3, 4'hF);
        waited = 0;
        while (m_phase != 48 && waited < 200) begin
            @(negedge WB_CLK);
            waited++;
        end
        check("reach_phase_48", {31'b0, (waited < 200)}, 32'd1);
        wr(17'h08, 32'd10, 4'hF);
        nr = 0;
        tog_at = '{default: -100};
        prev = clk_div_out;
        for (int k = 1; k <= 30 && nr < 3; k++) begin
            @(negedge WB_CLK);
            if (clk_div_out !== prev) begin
                tog_at[nr] = k;
                nr++;
            end
            prev = clk_div_out;
        end
        check("shrink_first_toggle", 32'(tog_at[0]), 32'd1);
        check("shrink_second_toggle", 32'(tog_at[1]), 32'd12);
        check("shrink_third_toggle", 32'(tog_at[2]), 32'd23);

        // Reset in the middle of a transfer
        @(negedge WB_CLK);
        WBs_ADR = 17'h10; WBs_WE = 1'b0; WBs_RD = 1'b1; WBs_CYC = 1'b1; WBs_STB = 1'b1;
        #2 WB_RST_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge WB_CLK);
            check("rst_mid_no_ack", {31'b0, WBs_ACK}, 32'd0);
            check("rst_mid_rd_dat", WBs_RD_DAT, 32'd0);
            check("rst_mid_clk_div", {31'b0, clk_div_out}, 32'd0);
        end
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_RD = 1'b0;
        @(negedge WB_CLK);
        WB_RST_N = 1'b1;
        rd_check("post_rst_ctrl", 17'h04, 32'h0);
        rd_check("post_rst_div", 17'h08, 32'h1);
        rd_check("post_rst_count", 17'h0C, 32'h0);
        rd_check("post_rst_scratch", 17'h10, 32'h0);
        rd_check("post_rst_unmapped_fc", 17'hFC, 32'h0);
        rd_check("post_rst_id", 17'h00, ID);
        repeat (3) @(negedge WB_CLK);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
